rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
Shares the register file's single write port between two writeback requesters: A is the in-order pipeline writeback, and B is the long-latency load/multiply unit. The block registers the granted write and drives the register file's reg_wr/wr_reg/wr_data. It also keeps a pending-destination scoreboard for B-issued operations, which the stall logic consumes. It sits between the writeback stage and the register file.

Parameters:
MAX_WAIT, 3, cycles B may be refused while valid before it is forced ahead of A (1..15)
XLEN, 32, data width

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
a_valid  input  1  requester A has a write
a_rd  input  5  A destination register
a_data  input  XLEN  A write data
a_ready  output  1  A write accepted this cycle
b_valid  input  1  requester B has a write
b_rd  input  5  B destination register
b_data  input  XLEN  B write data
b_ready  output  1  B write accepted this cycle
iss_valid  input  1  long-latency op issued to B this cycle
iss_rd  input  5  destination of the issued op
reg_wr  output  1  register file write enable
wr_reg  output  5  register file write address
wr_data  output  XLEN  register file write data
busy  output  32  scoreboard; bit n=1 means register n has a pending B write
force_b  output  1  starvation override active this cycle (debug)

Behaviour:
- Reset is clk/rst as decided: rst is asynchronous, active-high; clk is the clock.
- While rst is high: reg_wr=0, wr_reg=0, wr_data=0, busy=0, wait_cnt=0. a_ready, b_ready and force_b are also held at 0.
- Handshake: a transfer occurs on a clock edge where valid&&ready. ready is combinational from valid and wait_cnt and never depends on ready of the other port.
- Requester obligations: once valid is asserted, rd and data stay stable until accepted. The arbiter does not check this.
- Arbitration per cycle, with force_b = b_valid && (wait_cnt == MAX_WAIT):
  - force_b=1: b_ready=1, a_ready=0.
  - otherwise a_valid=1: a_ready=1, b_ready=0.
  - otherwise: b_ready=b_valid.
  - At most one ready is high in any cycle.
- wait_cnt (4-bit):
  - Increments when b_valid && !b_ready.
  - Clears to 0 when B is accepted or b_valid=0.
  - Saturates at MAX_WAIT.
- Output stage, latency 1: a transfer at edge N drives reg_wr=1, wr_reg=rd, wr_data=data for the cycle after edge N.
  - With no transfer, reg_wr=0 and wr_reg/wr_data hold their previous values.
- x0 filter: a transfer with rd=0 is accepted (ready asserted normally) but produces reg_wr=0.
- Scoreboard:
  - iss_valid sets busy[iss_rd]; setting busy[0] is suppressed.
  - A B transfer clears busy[b_rd].
  - Simultaneous set and clear of the same register: set wins, because a new issue supersedes.
  - A transfers never touch busy.
  - busy[0] is always 0.
- Reset mid-operation: in-flight handshakes are discarded, the output write is cancelled (reg_wr=0 immediately), and the scoreboard clears. Requesters must re-present after reset.
- Throughput: one write per cycle sustained, with no bubbles between back-to-back grants.

Optional Feature:
- Macro: WBARB_CONFLICT_CNT_EN.
- When defined:
  - Adds output conflict_cnt[15:0].
  - conflict_cnt increments on each cycle with a_valid && b_valid, saturating at 16'hFFFF.
  - Reset value is 0.
- When undefined: the port and counter do not exist, and all other behaviour is identical.

Test Plan:
- Reset then idle: assert rst mid-cycle -> reg_wr=0, busy=0, both readys 0 during rst; readys follow the rules after release.
- A-only: a_valid=1, a_rd=5, a_data=32'hDEADBEEF for one cycle -> a_ready=1; next cycle reg_wr=1, wr_reg=5, wr_data=32'hDEADBEEF; the cycle after, reg_wr=0.
- Starvation with MAX_WAIT=3: A and B valid continuously (b_rd=7, b_data=32'h11) -> A granted 3 cycles; 4th cycle force_b=1, b_ready=1, a_ready=0; next cycle wr_reg=7; wait_cnt then returns to 0 and A resumes.
- Scoreboard: iss_valid with iss_rd=9 -> busy[9]=1 the next cycle. Later, B writes rd=9 in the same cycle as iss_valid with iss_rd=9 -> busy[9] stays 1. A B write to rd=9 with no issue -> busy[9]=0.
- x0 filter: A writes rd=0, data=32'hFFFF -> a_ready=1, reg_wr stays 0. iss_rd=0 -> busy[0] stays 0.
- Reset mid-write: B accepted at edge N, rst asserted before edge N+1 -> reg_wr drops to 0 asynchronously and busy clears. With WBARB_CONFLICT_CNT_EN defined, 5 cycles of both valid -> conflict_cnt=5, and rst -> 0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register file write port between the in-order
// writeback (A) and the long-latency load/multiply unit (B). A has priority
// until B has been refused MAX_WAIT consecutive cycles, then B is forced
// ahead. The granted write is registered one cycle before reaching the
// register file. A pending-destination scoreboard tracks B-issued ops.
// Optional feature macro: WBARB_CONFLICT_CNT_EN adds a saturating 16-bit
// count of cycles where both requesters were valid (conflict_cnt).
module rf_wb_arbiter #(
   parameter int MAX_WAIT = 3,
   parameter int XLEN     = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            a_valid,
   input  logic [4:0]      a_rd,
   input  logic [XLEN-1:0] a_data,
   output logic            a_ready,
   input  logic            b_valid,
   input  logic [4:0]      b_rd,
   input  logic [XLEN-1:0] b_data,
   output logic            b_ready,
   input  logic            iss_valid,
   input  logic [4:0]      iss_rd,
   output logic            reg_wr,
   output logic [4:0]      wr_reg,
   output logic [XLEN-1:0] wr_data,
   output logic [31:0]     busy,
   output logic            force_b
`ifdef WBARB_CONFLICT_CNT_EN
   ,
   output logic [15:0]     conflict_cnt
`endif
);

   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   logic            force_b_s;
   logic            a_ready_s;
   logic            b_ready_s;
   logic            a_xfer_s;
   logic            b_xfer_s;
   logic [3:0]      wait_cnt_d, wait_cnt_q;
   logic            reg_wr_d, reg_wr_q;
   logic [4:0]      wr_reg_d, wr_reg_q;
   logic [XLEN-1:0] wr_data_d, wr_data_q;
   logic [31:0]     busy_d, busy_q;

   // Grant decision: starvation override first, then A priority, then B; all held low in reset.
   always_comb begin
      force_b_s = 1'b0;
      a_ready_s = 1'b0;
      b_ready_s = 1'b0;
      if (rst) begin
         force_b_s = 1'b0;
      end else begin
         force_b_s = b_valid && (wait_cnt_q == MAX_WAIT_C);
         if (force_b_s) begin
            b_ready_s = 1'b1;
         end else if (a_valid) begin
            a_ready_s = 1'b1;
         end else begin
            b_ready_s = b_valid;
         end
      end
   end

   assign a_xfer_s = a_valid && a_ready_s;
   assign b_xfer_s = b_valid && b_ready_s;

   // Next-state for the refusal counter, write stage and scoreboard.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      reg_wr_d   = 1'b0;
      wr_reg_d   = wr_reg_q;
      wr_data_d  = wr_data_q;
      busy_d     = busy_q;

      // B refused while valid ages the counter; acceptance or idle B restarts it.
      if (b_valid && !b_ready_s) begin
         if (wait_cnt_q < MAX_WAIT_C) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
         end else begin
            wait_cnt_d = wait_cnt_q;
         end
      end else begin
         wait_cnt_d = 4'd0;
      end

      // Writes to x0 are accepted but never reach the register file.
      if (a_xfer_s && (a_rd != 5'd0)) begin
         reg_wr_d  = 1'b1;
         wr_reg_d  = a_rd;
         wr_data_d = a_data;
      end else if (b_xfer_s && (b_rd != 5'd0)) begin
         reg_wr_d  = 1'b1;
         wr_reg_d  = b_rd;
         wr_data_d = b_data;
      end else begin
         reg_wr_d  = 1'b0;
      end

      // Clear before set so a same-cycle reissue of the register wins.
      if (b_xfer_s) begin
         busy_d[b_rd] = 1'b0;
      end else begin
         busy_d = busy_d;
      end
      if (iss_valid) begin
         busy_d[iss_rd] = 1'b1;
      end else begin
         busy_d = busy_d;
      end
      busy_d[0] = 1'b0;
   end

   // State registers; reset cancels any pending write and clears the scoreboard.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt_q <= 4'd0;
         reg_wr_q   <= 1'b0;
         wr_reg_q   <= 5'd0;
         wr_data_q  <= {XLEN{1'b0}};
         busy_q     <= 32'd0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         reg_wr_q   <= reg_wr_d;
         wr_reg_q   <= wr_reg_d;
         wr_data_q  <= wr_data_d;
         busy_q     <= busy_d;
      end
   end

`ifdef WBARB_CONFLICT_CNT_EN
   logic [15:0] conflict_cnt_d, conflict_cnt_q;

   // Count cycles where both requesters compete, saturating at all-ones.
   always_comb begin
      conflict_cnt_d = conflict_cnt_q;
      if (a_valid && b_valid && (conflict_cnt_q != 16'hFFFF)) begin
         conflict_cnt_d = conflict_cnt_q + 16'd1;
      end else begin
         conflict_cnt_d = conflict_cnt_q;
      end
   end

   // Conflict counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conflict_cnt_q <= 16'd0;
      end else begin
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   assign conflict_cnt = conflict_cnt_q;
`endif

   assign a_ready = a_ready_s;
   assign b_ready = b_ready_s;
   assign force_b = force_b_s;
   assign reg_wr  = reg_wr_q;
   assign wr_reg  = wr_reg_q;
   assign wr_data = wr_data_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (MAX_WAIT=3, XLEN=32).
module tb_rf_wb_arbiter;

   logic        clk;
   logic        rst;
   logic        a_valid;
   logic [4:0]  a_rd;
   logic [31:0] a_data;
   logic        a_ready;
   logic        b_valid;
   logic [4:0]  b_rd;
   logic [31:0] b_data;
   logic        b_ready;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic        reg_wr;
   logic [4:0]  wr_reg;
   logic [31:0] wr_data;
   logic [31:0] busy;
   logic        force_b;
`ifdef WBARB_CONFLICT_CNT_EN
   logic [15:0] conflict_cnt;
`endif

   int passed;
   int total;

   rf_wb_arbiter #(.MAX_WAIT(3), .XLEN(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .a_valid   (a_valid),
      .a_rd      (a_rd),
      .a_data    (a_data),
      .a_ready   (a_ready),
      .b_valid   (b_valid),
      .b_rd      (b_rd),
      .b_data    (b_data),
      .b_ready   (b_ready),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .reg_wr    (reg_wr),
      .wr_reg    (wr_reg),
      .wr_data   (wr_data),
      .busy      (busy),
      .force_b   (force_b)
`ifdef WBARB_CONFLICT_CNT_EN
      ,
      .conflict_cnt (conflict_cnt)
`endif
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      passed    = 0;
      total     = 0;
      rst       = 1'b1;
      a_valid   = 1'b1;
      a_rd      = 5'd1;
      a_data    = 32'h0;
      b_valid   = 1'b1;
      b_rd      = 5'd2;
      b_data    = 32'h0;
      iss_valid = 1'b0;
      iss_rd    = 5'd0;

      // Reset: outputs and readys held low even with requests pending
      #2;
      check("rst_a_ready", 32'(a_ready), 32'd0);
      check("rst_b_ready", 32'(b_ready), 32'd0);
      check("rst_force_b", 32'(force_b), 32'd0);
      check("rst_reg_wr",  32'(reg_wr),  32'd0);
      check("rst_busy",    busy,         32'd0);
      tick();
      tick();
      rst     = 1'b0;
      a_valid = 1'b0;
      b_valid = 1'b0;
      #1;
      check("idle_a_ready", 32'(a_ready), 32'd0);
      check("idle_b_ready", 32'(b_ready), 32'd0);
      b_valid = 1'b1;
      #1;
      check("idle_b_only_ready", 32'(b_ready), 32'd1);
      b_valid = 1'b0;

      // A-only write
      tick();
      a_valid = 1'b1;
      a_rd    = 5'd5;
      a_data  = 32'hDEADBEEF;
      #1;
      check("aonly_a_ready", 32'(a_ready), 32'd1);
      check("aonly_b_ready", 32'(b_ready), 32'd0);
      tick();
      a_valid = 1'b0;
      check("aonly_reg_wr",  32'(reg_wr),  32'd1);
      check("aonly_wr_reg",  32'(wr_reg),  32'd5);
      check("aonly_wr_data", wr_data,      32'hDEADBEEF);
      tick();
      check("aonly_reg_wr_drop", 32'(reg_wr), 32'd0);
      check("aonly_wr_reg_hold", 32'(wr_reg), 32'd5);
      check("aonly_wr_data_hold", wr_data,    32'hDEADBEEF);

      // Starvation: A wins three cycles, then B is forced
      a_valid = 1'b1;
      a_rd    = 5'd3;
      a_data  = 32'h33;
      b_valid = 1'b1;
      b_rd    = 5'd7;
      b_data  = 32'h11;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("starv_a_ready", 32'(a_ready), 32'd1);
         check("starv_force_b", 32'(force_b), 32'd0);
         tick();
         check("starv_a_wr",    32'(wr_reg),  32'd3);
         check("starv_reg_wr",  32'(reg_wr),  32'd1);
      end
      #1;
      check("starv_force_on", 32'(force_b), 32'd1);
      check("starv_b_ready",  32'(b_ready), 32'd1);
      check("starv_a_block",  32'(a_ready), 32'd0);
      tick();
      check("starv_b_wr_reg",  32'(wr_reg), 32'd7);
      check("starv_b_wr_data", wr_data,     32'h11);
      check("starv_b_reg_wr",  32'(reg_wr), 32'd1);
      // New B request: counter must have restarted, so A gets three more grants
      b_rd   = 5'd8;
      b_data = 32'h22;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("resume_a_ready", 32'(a_ready), 32'd1);
         check("resume_force_b", 32'(force_b), 32'd0);
         tick();
         check("resume_a_wr", 32'(wr_reg), 32'd3);
      end
      #1;
      check("resume_force_on", 32'(force_b), 32'd1);
      tick();
      a_valid = 1'b0;
      b_valid = 1'b0;
      check("resume_b_wr_reg",  32'(wr_reg), 32'd8);
      check("resume_b_wr_data", wr_data,     32'h22);
      check("starv_busy_clear", busy,        32'd0);

      // Scoreboard set, set-wins-over-clear, then clear
      iss_valid = 1'b1;
      iss_rd    = 5'd9;
      tick();
      iss_valid = 1'b0;
      check("sb_set9", busy, 32'h0000_0200);
      b_valid   = 1'b1;
      b_rd      = 5'd9;
      b_data    = 32'h99;
      iss_valid = 1'b1;
      iss_rd    = 5'd9;
      #1;
      check("sb_b_ready", 32'(b_ready), 32'd1);
      tick();
      b_valid   = 1'b0;
      iss_valid = 1'b0;
      check("sb_set_wins", busy,         32'h0000_0200);
      check("sb_b_wr_reg", 32'(wr_reg),  32'd9);
      b_valid = 1'b1;
      tick();
      b_valid = 1'b0;
      check("sb_clear9", busy, 32'd0);

      // x0 filter on A writes and on issue
      a_valid = 1'b1;
      a_rd    = 5'd0;
      a_data  = 32'hFFFF;
      #1;
      check("x0_a_ready", 32'(a_ready), 32'd1);
      tick();
      a_valid = 1'b0;
      check("x0_reg_wr", 32'(reg_wr), 32'd0);
      iss_valid = 1'b1;
      iss_rd    = 5'd0;
      tick();
      iss_valid = 1'b0;
      check("x0_busy0", busy, 32'd0);

      // Reset during an outstanding write
      b_valid   = 1'b1;
      b_rd      = 5'd4;
      b_data    = 32'h44;
      iss_valid = 1'b1;
      iss_rd    = 5'd10;
      tick();
      b_valid   = 1'b0;
      iss_valid = 1'b0;
      check("midrst_reg_wr_pre", 32'(reg_wr), 32'd1);
      check("midrst_busy_pre",   busy,        32'h0000_0400);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_reg_wr",  32'(reg_wr),  32'd0);
      check("midrst_busy",    busy,         32'd0);
      check("midrst_wr_data", wr_data,      32'd0);
      check("midrst_wr_reg",  32'(wr_reg),  32'd0);
      tick();
      rst = 1'b0;

`ifdef WBARB_CONFLICT_CNT_EN
      check("cc_reset", 32'(conflict_cnt), 32'd0);
      a_valid = 1'b1;
      a_rd    = 5'd1;
      b_valid = 1'b1;
      b_rd    = 5'd2;
      for (int i = 0; i < 5; i++) begin
         tick();
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
      check("cc_five", 32'(conflict_cnt), 32'd5);
      #2;
      rst = 1'b1;
      #1;
      check("cc_rst", 32'(conflict_cnt), 32'd0);
      tick();
      rst = 1'b0;
`endif

      tick();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
